// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
//   Groups the scan driver's control and display signals.
//   Parameters must match the NUM_DIGITS / DATA_WIDTH of the attached driver.
//   enable     : scan enable; low freezes the scan and blanks the display
//   value      : value to display, nibble i on digit i
//   seg        : segments, seg[0]=a .. seg[6]=g
//   digit_en   : one-hot digit select
//   frame_tick : one-cycle pulse when the digit index wraps
//   master : the side driving enable/value (CPU counter / testbench)
//   slave  : the display driver
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] value;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  frame_tick;

  modport master (
    output enable, value,
    input  seg, digit_en, frame_tick
  );

  modport slave (
    input  enable, value,
    output seg, digit_en, frame_tick
  );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed multi-digit hex seven-segment driver. Each digit slot
//   lasts REFRESH_DIV cycles, the first BLANK_CYCLES of which keep every
//   digit off to avoid ghosting. The displayed value is snapshotted once per
//   frame so a value changing mid-frame never tears.
// Ports:
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : seg_scan_display_if.slave (enable, value, seg, digit_en, frame_tick)
// Optional feature:
//   SEG_SCAN_LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//   (above digit 0) show no segments; digit_en timing is unaffected.
module seg_scan_display #(
  parameter int NUM_DIGITS       = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int REFRESH_DIV      = 1024,
  parameter int BLANK_CYCLES     = 16,
  parameter int SEG_ACTIVE_LOW   = 0,
  parameter int DIGIT_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_display_if.slave bus
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_scan_display: NUM_DIGITS must be 1..8");
  end
  if (DATA_WIDTH < 4 * NUM_DIGITS) begin : g_bad_data_width
    $error("seg_scan_display: DATA_WIDTH must be >= 4*NUM_DIGITS");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_scan_display: BLANK_CYCLES must be >= 1");
  end
  if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_refresh
    $error("seg_scan_display: REFRESH_DIV must be >= BLANK_CYCLES+2");
  end

  localparam int SW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         snap;
  logic                  frame_tick_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] digit_en_q;

  logic                  frame_start;
  logic                  slot_end;
  logic [SW-1:0]         snap_shifted;
  logic [3:0]            nib;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] dig_raw;
  logic                  unused_value_bits;

  // Only the low 4*NUM_DIGITS bits of value are displayed.
  assign unused_value_bits = ^bus.value;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = '0;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign frame_start  = bus.enable && (idx == '0) && (presc == '0);
  assign slot_end     = (presc == PRESC_MAX);
  // Shifting the snapshot down by 4*idx puts the current nibble at [3:0]
  // and leaves only this digit and the higher ones in the word.
  assign snap_shifted = snap >> {idx, 2'b00};
  assign nib          = snap_shifted[3:0];

  always_comb begin
    seg_raw = '0;
    dig_raw = '0;
    if (bus.enable && (presc >= BLANK_END)) begin
      dig_raw = DIG_ONE << idx;
      seg_raw = decode(nib);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if ((idx != '0) && (snap_shifted == '0)) begin
        seg_raw = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc        <= '0;
      idx          <= '0;
      snap         <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_INV;
      digit_en_q   <= DIG_INV;
    end else begin
      frame_tick_q <= 1'b0;
      if (bus.enable) begin
        if (slot_end) begin
          presc        <= '0;
          idx          <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
          frame_tick_q <= (idx == IDX_MAX);
        end else begin
          presc <= presc + PW'(1);
        end
        if (frame_start) begin
          snap <= bus.value[SW-1:0];
        end
      end
      seg_q      <= seg_raw ^ SEG_INV;
      digit_en_q <= dig_raw ^ DIG_INV;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
  localparam int ND = 4;
  localparam int DW = 32;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = ND * RD;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg_scan_display_if #(.NUM_DIGITS(ND), .DATA_WIDTH(DW)) bus ();
  seg_scan_display_if #(.NUM_DIGITS(ND), .DATA_WIDTH(DW)) pbus ();

  assign pbus.enable = bus.enable;
  assign pbus.value  = bus.value;

  seg_scan_display #(
    .NUM_DIGITS(ND), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  seg_scan_display #(
    .NUM_DIGITS(ND), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut_pol (
    .clk(clk), .reset(rst_n), .bus(pbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: t counts enabled edges since reset; slot position and
  // digit are plain arithmetic on t; the snapshot is the value seen at the
  // edge that starts each frame.
  logic [6:0]    glyph [16];
  int            t;
  logic [15:0]   msnap;
  logic [6:0]    e_seg;
  logic [ND-1:0] e_dig;
  logic          e_ft;

  task automatic model_edge();
    int p;
    int d;
    if (!rst_n) begin
      t = 0; msnap = '0; e_seg = '0; e_dig = '0; e_ft = 1'b0;
    end else begin
      p = t % RD;
      d = (t / RD) % ND;
      e_seg = '0;
      e_dig = '0;
      if (bus.enable && p >= BL) begin
        e_dig = ND'(1 << d);
        e_seg = glyph[(msnap >> (4 * d)) & 16'hF];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (d > 0 && (msnap >> (4 * d)) == 16'h0) e_seg = '0;
`endif
      end
      e_ft = 1'b0;
      if (bus.enable) begin
        if (t % FR == 0) msnap = bus.value[15:0];
        if (t % FR == FR - 1) e_ft = 1'b1;
        t = t + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sync_to(input int target);
    for (int i = 0; i < 2 * FR && (t % FR) != target; i++) tick();
    if ((t % FR) != target) begin
      errors++;
      $display("FAIL sync_to: position %0d, required %0d", t % FR, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.value = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {7'h00, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset_main: seg=%h dig=%b ft=%b required seg=00 dig=0000 ft=0",
                 bus.seg, bus.digit_en, bus.frame_tick);
      end
      checks++;
      if ({pbus.seg, pbus.digit_en} !== {7'h7F, 4'hF}) begin
        errors++;
        $display("FAIL reset_pol: seg=%h dig=%b required seg=7f dig=1111",
                 pbus.seg, pbus.digit_en);
      end
      checks++;
    end
  endtask

  task automatic test_basic_scan();
    logic [6:0] obs [4];
    logic [6:0] req [4];
    int ft_cnt;
    int lit_cnt;
    req = '{7'h71, 7'h77, 7'h5B, 7'h06};
    bus.value = 32'h0000_12AF;
    rst_n = 1'b1;
    sync_to(0);
    ft_cnt = 0;
    lit_cnt = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
        errors++;
        $display("FAIL basic_scan k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                 k, bus.seg, bus.digit_en, bus.frame_tick, e_seg, e_dig, e_ft);
      end
      checks++;
      if (bus.frame_tick) ft_cnt++;
      if (bus.digit_en != '0) lit_cnt++;
      if (k < FR && k % RD == RD - 1) obs[k / RD] = bus.seg;
    end
    for (int d = 0; d < ND; d++) begin
      if (obs[d] !== req[d]) begin
        errors++;
        $display("FAIL basic_glyph digit%0d: seg=%h required %h", d, obs[d], req[d]);
      end
      checks++;
    end
    if (ft_cnt != 2) begin
      errors++;
      $display("FAIL basic_frame_tick: %0d pulses in 64 cycles, required 2", ft_cnt);
    end
    checks++;
    if (lit_cnt != 2 * ND * (RD - BL)) begin
      errors++;
      $display("FAIL basic_lit_cycles: %0d, required %0d", lit_cnt, 2 * ND * (RD - BL));
    end
    checks++;
  endtask

  task automatic test_anti_tearing();
    logic [6:0] obs [8];
    logic [6:0] req [8];
    req = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h7F, 7'h07, 7'h7D, 7'h6D};
    bus.value = 32'h0000_1234;
    sync_to(0);
    for (int k = 0; k < 2 * FR; k++) begin
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
        errors++;
        $display("FAIL anti_tearing k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                 k, bus.seg, bus.digit_en, bus.frame_tick, e_seg, e_dig, e_ft);
      end
      checks++;
      if (k == RD + 3) bus.value = 32'h0000_5678;
      if (k % RD == RD - 1) obs[k / RD] = bus.seg;
    end
    for (int s = 0; s < 8; s++) begin
      if (obs[s] !== req[s]) begin
        errors++;
        $display("FAIL tearing_glyph slot%0d: seg=%h required %h", s, obs[s], req[s]);
      end
      checks++;
    end
  endtask

  task automatic test_freeze();
    int lit;
    bus.value = 32'h0000_9C3E;
    sync_to(2 * RD + 4);
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {7'h00, 4'h0, 1'b0} ||
          {bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
        errors++;
        $display("FAIL freeze_blank k=%0d: seg=%h dig=%b ft=%b required all off",
                 k, bus.seg, bus.digit_en, bus.frame_tick);
      end
      checks++;
    end
    bus.enable = 1'b1;
    lit = 0;
    for (int k = 0; k < RD - 4 + 1; k++) begin
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
        errors++;
        $display("FAIL freeze_resume k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                 k, bus.seg, bus.digit_en, bus.frame_tick, e_seg, e_dig, e_ft);
      end
      checks++;
      if (bus.digit_en == 4'b0100) lit++;
    end
    if (lit != RD - 4) begin
      errors++;
      $display("FAIL freeze_remaining: digit2 lit %0d cycles after resume, required %0d",
               lit, RD - 4);
    end
    checks++;
  endtask

  task automatic test_reset_midframe();
    sync_to(3 * RD + 3);
    rst_n = 1'b0;
    tick();
    if ({bus.seg, bus.digit_en, bus.frame_tick} !== {7'h00, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: seg=%h dig=%b ft=%b required all off",
               bus.seg, bus.digit_en, bus.frame_tick);
    end
    checks++;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (bus.digit_en !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL first_light edge%0d: dig=%b required %b",
                 k, bus.digit_en, (k == 3) ? 4'b0001 : 4'b0000);
      end
      checks++;
    end
  endtask

  task automatic test_polarity();
    bus.value = 32'h0000_0008;
    rst_n = 1'b0;
    tick();
    if ({pbus.seg, pbus.digit_en} !== {7'h7F, 4'hF}) begin
      errors++;
      $display("FAIL pol_reset: seg=%h dig=%b required seg=7f dig=1111",
               pbus.seg, pbus.digit_en);
    end
    checks++;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    if ({pbus.seg, pbus.digit_en} !== {7'h00, 4'b1110}) begin
      errors++;
      $display("FAIL pol_lit: seg=%h dig=%b required seg=00 dig=1110",
               pbus.seg, pbus.digit_en);
    end
    checks++;
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [2];
    logic [6:0]  obs [4];
    logic [6:0]  req [4];
    vals = '{16'h0030, 16'h0000};
    for (int v = 0; v < 2; v++) begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (v == 0) req = '{7'h3F, 7'h4F, 7'h00, 7'h00};
      else        req = '{7'h3F, 7'h00, 7'h00, 7'h00};
`else
      if (v == 0) req = '{7'h3F, 7'h4F, 7'h3F, 7'h3F};
      else        req = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif
      bus.value = {16'h0, vals[v]};
      sync_to(0);
      for (int k = 0; k < FR; k++) begin
        tick();
        if ({bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
          errors++;
          $display("FAIL leading_zero k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                   k, bus.seg, bus.digit_en, bus.frame_tick, e_seg, e_dig, e_ft);
        end
        checks++;
        if (k % RD == RD - 1) begin
          obs[k / RD] = bus.seg;
          if (bus.digit_en !== ND'(1 << (k / RD))) begin
            errors++;
            $display("FAIL lz_digit_en slot%0d: dig=%b required %b",
                     k / RD, bus.digit_en, ND'(1 << (k / RD)));
          end
          checks++;
        end
      end
      for (int d = 0; d < ND; d++) begin
        if (obs[d] !== req[d]) begin
          errors++;
          $display("FAIL lz_glyph value=%h digit%0d: seg=%h required %h",
                   vals[v], d, obs[d], req[d]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) bus.value = $urandom;
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      if ({bus.seg, bus.digit_en, bus.frame_tick} !== {e_seg, e_dig, e_ft}) begin
        errors++;
        $display("FAIL random k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                 k, bus.seg, bus.digit_en, bus.frame_tick, e_seg, e_dig, e_ft);
      end
      checks++;
      if ({pbus.seg, pbus.digit_en, pbus.frame_tick} !== {~e_seg, ~e_dig, e_ft}) begin
        errors++;
        $display("FAIL random_pol k=%0d: seg=%h dig=%b ft=%b required seg=%h dig=%b ft=%b",
                 k, pbus.seg, pbus.digit_en, pbus.frame_tick, ~e_seg, ~e_dig, e_ft);
      end
      checks++;
    end
    bus.enable = 1'b1;
    rst_n = 1'b1;
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks = 0;
    errors = 0;
    t = 0;
    msnap = '0;
    test_reset();
    test_basic_scan();
    test_anti_tearing();
    test_freeze();
    test_reset_midframe();
    test_polarity();
    test_leading_zero();
    test_random();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
